// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard/stall controller:
//   - hz_state_e   : controller state (RUN, MC_BUSY)
//   - HZ_REG_W     : default register-specifier width
//   - MC_CNT_W     : width of the multi-cycle occupancy down-counter
//   - pipe_ctrl_t  : bundle of pipeline-register controls, with named
//                    constant records for each control pattern the
//                    controller can drive.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  localparam int HZ_REG_W = 4;
  localparam int MC_CNT_W = 4;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_bubble;
  } pipe_ctrl_t;

  // Normal flow: every stage advances, nothing squashed.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
    idex_we: 1'b1, idex_bubble: 1'b0, exmem_bubble: 1'b0
  };

  // Held while reset is asserted: nothing advances and every
  // downstream register is loaded with a NOP.
  localparam pipe_ctrl_t CTRL_NOP = '{
    pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
    idex_we: 1'b0, idex_bubble: 1'b1, exmem_bubble: 1'b1
  };

  // Multi-cycle op occupies EX: front end frozen, EX/MEM gets bubbles
  // until the result is released.
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
    idex_we: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1
  };

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  // idex_we stays high; the bubble takes precedence at ID/EX.
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
    idex_we: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0
  };

  // Taken branch: PC loads the target, the two younger instructions
  // (in IF/ID and ID) are squashed.
  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
    idex_we: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0
  };

  // Counter preload for a multi-cycle op of the given EX latency.
  // The entry cycle is spent in RUN, so the busy phase starts at
  // lat-2 and the cycle with a zero count is the release cycle.
  function automatic logic [MC_CNT_W-1:0] mc_load_value(input int lat);
    return MC_CNT_W'(lat - 2);
  endfunction

endpackage

// File: rtl/mc_cycle_counter.sv
// mc_cycle_counter
//   Loadable down-counter with a zero flag, used to time how long a
//   multi-cycle op stays in EX.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset (count -> 0)
//     load      in   load load_val (wins over dec)
//     load_val  in   W  preload value
//     dec       in   decrement by one; holds at zero
//     zero      out  count is zero
module mc_cycle_counter
  import hazard_pkg::*;
#(
  parameter int W = MC_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Stall/flush sequencer for the ID/EX boundary. Handles the hazards
//   forwarding cannot: load-use stalls, front-end freeze while a
//   multi-cycle op occupies EX, and squash on a taken branch.
//   Ports:
//     clk, rst                   clock / async active-high reset
//     id_rs1, id_rs2             source specifiers of the ID instruction
//     id_uses_rs1, id_uses_rs2   ID instruction really reads that source
//     ex_rd                      destination of the EX instruction
//     ex_mem_read                EX instruction is a load
//     ex_is_mc                   EX instruction is a multi-cycle op
//     branch_taken               branch resolved taken in EX
//     pc_we, ifid_we, ifid_flush,
//     idex_we, idex_bubble,
//     exmem_bubble               pipeline-register controls (combinational)
//     mc_busy                    controller is in MC_BUSY
//     stall_cycles               saturating count of cycles with pc_we=0
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_W  = HZ_REG_W,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_mc,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [MC_CNT_W-1:0] MC_LOAD = mc_load_value(MC_LAT);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  hz_state_e  state_reg;
  hz_state_e  state_next;
  pipe_ctrl_t ctrl;
  logic       mc_start;
  logic       mc_dec;
  logic       mc_zero;
  logic       load_use;

  logic [CNT_W-1:0] stall_cycles_reg;

  // --------------------------------------------------------------
  // Load-use detection: one comparator per ID source operand.
  // r0 is hardwired zero, so a load targeting it never creates a
  // dependency.
  // --------------------------------------------------------------
  logic [REG_W-1:0] src_reg [2];
  logic [1:0]       src_used;
  logic [1:0]       src_hit;

  assign src_reg[0]  = id_rs1;
  assign src_reg[1]  = id_rs2;
  assign src_used[0] = id_uses_rs1;
  assign src_used[1] = id_uses_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = src_used[gi] && (src_reg[gi] == ex_rd);
    end
  endgenerate

  assign load_use = ex_mem_read && (ex_rd != '0) && (|src_hit);

  // --------------------------------------------------------------
  // Multi-cycle occupancy timer. Loaded on the entry cycle (in RUN),
  // counts down through MC_BUSY; the zero-count cycle is the release.
  // --------------------------------------------------------------
  assign mc_dec = (state_reg == MC_BUSY) && !mc_zero;

  mc_cycle_counter #(
    .W(MC_CNT_W)
  ) u_mc_cycle_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_start),
    .load_val (MC_LOAD),
    .dec      (mc_dec),
    .zero     (mc_zero)
  );

  // --------------------------------------------------------------
  // Control selection and next state. Reset overrides everything so
  // the pipe registers see NOPs for as long as rst is high.
  // --------------------------------------------------------------
  always_comb begin
    ctrl       = CTRL_RUN;
    state_next = state_reg;
    mc_start   = 1'b0;
    if (rst) begin
      ctrl = CTRL_NOP;
    end else begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            // A taken branch squashes ID, so an MC op or load-use
            // seen there is irrelevant this cycle.
            ctrl = CTRL_BRANCH;
          end else if (ex_is_mc) begin
            ctrl       = CTRL_FREEZE;
            mc_start   = 1'b1;
            state_next = MC_BUSY;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        MC_BUSY: begin
          // The MC op owns EX: branch and load inputs are not
          // meaningful here and are deliberately ignored.
          if (!mc_zero) begin
            ctrl = CTRL_FREEZE;
          end else begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stall-cycle counter: any cycle where the PC is held counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (!ctrl.pc_we && (stall_cycles_reg != CNT_MAX)) begin
      stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_we      = ctrl.idex_we;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign mc_busy      = !rst && (state_reg == MC_BUSY);
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller sitting beside the forwarding unit in the ID/EX boundary. Forwarding resolves RAW hazards that only need a bypass; this block handles those that cannot be bypassed. It stalls on load-use hazards, freezes the front of the pipe while a multi-cycle ALU op (mul/div) occupies EX, and flushes on a taken branch. It drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM, and keeps a saturating stall-cycle counter.

## Interface
- REG_W, 4, register-specifier width (16-entry register file, r0 hardwired zero)
- MC_LAT, 4, EX occupancy in cycles of a multi-cycle op; legal range 2..16
- CNT_W, 16, width of stall-cycle counter

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  REG_W  source specifiers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads that source
- ex_rd  in  REG_W  destination of instruction in EX (from ID/EX)
- ex_mem_read  in  1  EX instruction is a load
- ex_is_mc  in  1  EX instruction is a multi-cycle op
- branch_taken  in  1  branch resolved taken in EX this cycle
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_we  out  1  ID/EX register enable
- idex_bubble  out  1  ID/EX loads a NOP (wins over idex_we)
- exmem_bubble  out  1  EX/MEM loads a NOP
- mc_busy  out  1  state is MC_BUSY
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- States: RUN, MC_BUSY. Down-counter mc_cnt, width 4.
- Defaults (RUN, no event): pc_we=1, ifid_we=1, idex_we=1, all bubble/flush=0.
- Priority in RUN, highest first:
  - branch_taken: ifid_flush=1, idex_bubble=1, pc_we=1 (target load).
  - ex_is_mc: pc_we=0, ifid_we=0, idex_we=0, exmem_bubble=1. Next state MC_BUSY, mc_cnt<=MC_LAT-2.
  - Load-use: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && ex_rd==id_rs1) || (id_uses_rs2 && ex_rd==id_rs2)). Sets pc_we=0, ifid_we=0, idex_bubble=1 for exactly one cycle, with no state change.
- MC_BUSY:
  - mc_cnt!=0: same freeze outputs as the MC entry cycle; mc_cnt decrements.
  - mc_cnt==0: default outputs, which releases the result into EX/MEM. Next state RUN.
  - branch_taken and ex_mem_read are ignored, since an MC op occupies EX.
- Stall cycles total MC_LAT-1 per MC op; the op spends MC_LAT cycles in EX.
- stall_cycles increments on every cycle with pc_we=0 outside reset and saturates at all-ones.
- Load-use with ex_rd==0, or with the matching id_uses_* low, produces no stall.
- Back-to-back MC ops: the second is seen in RUN on the cycle after release and re-enters MC_BUSY.

## Timing
- Controls are combinational from state and inputs and are valid the same cycle. State, mc_cnt and stall_cycles are registered.
- While rst=1, outputs are forced to: pc_we=0, ifid_we=0, idex_we=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, mc_busy=0.
- Reset asynchronously sets state=RUN, mc_cnt=0, stall_cycles=0.
- Reset mid-MC_BUSY aborts immediately. After deassertion the block is in RUN with default outputs.
- Load-use penalty is 1 cycle. MC penalty is MC_LAT-1 cycles. Branch penalty is 2 squashed instructions, with no stall.

## Structure
- Shared package hazard_pkg holds: state enum typedef (RUN, MC_BUSY), REG_W default, and a NOP-control constant record for bubble encoding.
- One sub-module: mc_cycle_counter, a loadable 4-bit down-counter with a zero flag.
- Load-use compare logic and output muxing stay in the top module.

## Test plan
- Reset mid-MC_BUSY (mc_cnt=2), deassert -> state RUN, mc_busy=0, default outputs on the next cycle, stall_cycles=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1, then defaults; stall_cycles +1. Repeat with ex_rd=0 -> no stall.
- MC_LAT=4, ex_is_mc held high -> 3 cycles freeze with exmem_bubble=1, 4th cycle defaults, stall_cycles +3. Second MC op immediately after -> re-freeze.
- branch_taken=1 with a simultaneous load-use match -> ifid_flush=1, idex_bubble=1, pc_we=1; no stall.
- Force stall_cycles near saturation (CNT_W=4, 6 load-use stalls from 12) -> counter holds at 15.
